sram_port_arbiter: RTL and testbench

Shares one single-port SRAM macro (active-low chip/write enables, 1-cycle registered read) between one write requester and one read requester in the cache data-storage path. Accepts valid/ready requests, grants at most one SRAM access per cycle, and captures read data into a 2-entry response buffer with backpressure. A bounded read-priority policy lets reads win by default, while a streak counter guarantees write forward progress.

---
 rtl/sram_port_arbiter_pkg.sv | 24 ++
 rtl/sram_port_arbiter_if.sv | 43 ++++
 rtl/sram_resp_fifo.sv | 48 ++++
 rtl/sram_port_arbiter.sv | 113 +++++++++++
 tb/tb_sram_port_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// rtl/sram_port_arbiter_pkg.sv - shared types for the SRAM port arbiter
//
// Purpose: grant encoding and the SRAM request record used by the arbiter top.
// Ports: none (package).
package sram_port_arbiter_pkg;

    localparam int SRAM_ADDR_W = 10;
    localparam int SRAM_DATA_W = 64;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_RD,
        GNT_WR
    } gnt_e;

    // One cycle's drive onto the macro pins; ceb/web are active low.
    typedef struct packed {
        logic                   ceb;
        logic                   web;
        logic [SRAM_ADDR_W-1:0] addr;
        logic [SRAM_DATA_W-1:0] data;
    } sram_req_t;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// rtl/sram_port_arbiter_if.sv - requester, response and SRAM macro signal bundle
//
// Purpose: groups the write/read request handshakes, the read response
//          handshake and the SRAM macro pins.
// Modports: slave  - arbiter side (takes requests, drives grants, response, macro pins)
//           master - requester/environment side (the mirror image)
interface sram_port_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
);

    logic              w_valid;
    logic              w_ready;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

    logic              r_valid;
    logic              r_ready;
    logic [ADDR_W-1:0] r_addr;

    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;

    logic              sram_ceb;
    logic              sram_web;
    logic [ADDR_W-1:0] sram_a;
    logic [DATA_W-1:0] sram_d;
    logic [DATA_W-1:0] sram_q;

    modport slave (
        input  w_valid, w_addr, w_data, r_valid, r_addr, resp_ready, sram_q,
        output w_ready, r_ready, resp_valid, resp_data,
               sram_ceb, sram_web, sram_a, sram_d
    );

    modport master (
        output w_valid, w_addr, w_data, r_valid, r_addr, resp_ready, sram_q,
        input  w_ready, r_ready, resp_valid, resp_data,
               sram_ceb, sram_web, sram_a, sram_d
    );

endinterface

// File: rtl/sram_resp_fifo.sv
// rtl/sram_resp_fifo.sv - 2-entry read response buffer
//
// Purpose: holds SRAM read data until the response consumer takes it.
// Ports: clock, reset_n (async active low); push/push_data capture an entry;
//        pop releases the head; count = occupancy 0..2; head_data = oldest entry.
// The caller never pushes when full (without a pop) nor pops when empty.
module sram_resp_fifo #(
    parameter int DATA_W = 64
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [1:0]        count,
    output logic [DATA_W-1:0] head_data
);

    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - single-port SRAM shared by one writer and one reader
//
// Purpose: grants at most one SRAM access per cycle, reads preferred but a
//          write wins after MAX_RD_STREAK consecutive read grants while it waits.
//          Read data lands in a 2-entry response buffer two cycles after grant.
// Ports: clock, reset_n (async active low); bus (slave modport) carries the
//        w_*/r_* request handshakes, resp_* response handshake and sram_* pins.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W        = SRAM_ADDR_W,
    parameter int DATA_W        = SRAM_DATA_W,
    parameter int MAX_RD_STREAK = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    sram_port_arbiter_if.slave  bus
);

    localparam int STREAK_W = $clog2(MAX_RD_STREAK + 1);

    gnt_e              gnt;
    sram_req_t         req;
    sram_req_t         last_req;
    logic              inflight;
    logic [STREAK_W-1:0] streak;
    logic [1:0]        count;
    logic [DATA_W-1:0] head_data;
    logic              resp_fire;
    logic              rd_elig;
    logic              streak_full;
    logic [ADDR_W-1:0] gnt_addr;

    assign resp_fire   = bus.resp_valid && bus.resp_ready;
    assign streak_full = (streak == STREAK_W'(MAX_RD_STREAK));

    // A read may issue only if it still fits in the buffer once this
    // cycle's pop is accounted for, counting the read already in flight.
    assign rd_elig = bus.r_valid &&
                     (({1'b0, count} + {2'b00, inflight}) < (3'd2 + {2'b00, resp_fire}));

    always_comb begin
        gnt = GNT_NONE;
        // Grants are held off while reset is asserted so the ready outputs
        // and macro pins sit at their idle values.
        if (reset_n) begin
            if (bus.w_valid && (!rd_elig || streak_full)) begin
                gnt = GNT_WR;
            end else if (rd_elig) begin
                gnt = GNT_RD;
            end
        end
    end

    assign gnt_addr = (gnt == GNT_WR) ? bus.w_addr : bus.r_addr;

    // Address/data pins keep their last driven value when idle.
    always_comb begin
        req     = last_req;
        req.ceb = 1'b1;
        req.web = 1'b1;
        case (gnt)
            GNT_WR: begin
                req.ceb  = 1'b0;
                req.web  = 1'b0;
                req.addr = gnt_addr;
                req.data = bus.w_data;
            end
            GNT_RD: begin
                req.ceb  = 1'b0;
                req.addr = gnt_addr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_req <= '{ceb: 1'b1, web: 1'b1, addr: '0, data: '0};
            inflight <= 1'b0;
            streak   <= '0;
        end else begin
            last_req <= req;
            inflight <= (gnt == GNT_RD);
            if (gnt == GNT_WR || !bus.w_valid) begin
                streak <= '0;
            end else if (gnt == GNT_RD && !streak_full) begin
                streak <= streak + 1'b1;
            end
        end
    end

    // sram_q is only meaningful the cycle after a read issue.
    sram_resp_fifo #(.DATA_W(DATA_W)) u_resp_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (inflight),
        .push_data (bus.sram_q),
        .pop       (resp_fire),
        .count     (count),
        .head_data (head_data)
    );

    assign bus.w_ready    = (gnt == GNT_WR);
    assign bus.r_ready    = (gnt == GNT_RD);
    assign bus.resp_valid = (count != 2'd0);
    assign bus.resp_data  = head_data;
    assign bus.sram_ceb   = req.ceb;
    assign bus.sram_web   = req.web;
    assign bus.sram_a     = req.addr;
    assign bus.sram_d     = req.data;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - self-checking bench for sram_port_arbiter
module tb_sram_port_arbiter;

    localparam int AW  = 10;
    localparam int DW  = 64;
    localparam int MAX = 4;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    sram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_RD_STREAK(MAX)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // SRAM macro: 1-cycle registered read, garbage on q when not reading.
    logic [DW-1:0] macro_mem [1024];
    always @(posedge clock) begin
        if (!bus.sram_ceb && !bus.sram_web) macro_mem[bus.sram_a] <= bus.sram_d;
        if (!bus.sram_ceb && bus.sram_web) bus.sram_q <= macro_mem[bus.sram_a];
        else bus.sram_q <= {$urandom, $urandom};
    end

    // Reference model: memory contents as seen by requesters, and a queue of
    // accepted reads tagged with their grant cycle.
    typedef struct {
        logic [DW-1:0] data;
        int            gcyc;
    } rd_t;

    rd_t           rq[$];
    logic [DW-1:0] ref_mem [1024];
    int            streak_m;
    logic [AW-1:0] last_a;
    logic [DW-1:0] last_d;
    int            cyc;

    logic          e_wr, e_rd, e_rv, e_ceb, e_web;
    logic [DW-1:0] e_rdata, e_d;
    logic [AW-1:0] e_a;
    logic          cur_wv, cur_fire;
    logic [AW-1:0] cur_wa, cur_ra;
    logic [DW-1:0] cur_wd;

    int total = 0;
    int bad   = 0;

    task automatic model_reset();
        rq.delete();
        streak_m = 0;
        last_a   = '0;
        last_d   = '0;
        cyc      = 0;
    endtask

    // Apply inputs after the falling edge and derive expected outputs.
    task automatic drive(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic rv, input logic [AW-1:0] ra, input logic rr);
        logic rd_ok;
        @(negedge clock);
        bus.w_valid = wv; bus.w_addr = wa; bus.w_data = wd;
        bus.r_valid = rv; bus.r_addr = ra; bus.resp_ready = rr;
        cur_wv = wv; cur_wa = wa; cur_wd = wd; cur_ra = ra;
        e_rv     = (rq.size() > 0) && (rq[0].gcyc <= cyc - 2);
        e_rdata  = e_rv ? rq[0].data : '0;
        cur_fire = e_rv && rr;
        rd_ok    = rv && ((rq.size() - int'(cur_fire)) < 2);
        e_wr     = wv && (!rd_ok || streak_m == MAX);
        e_rd     = rd_ok && !e_wr;
        e_ceb    = !(e_wr || e_rd);
        e_web    = !e_wr;
        e_a      = e_wr ? wa : (e_rd ? ra : last_a);
        e_d      = e_wr ? wd : last_d;
        #2;
    endtask

    task automatic commit();
        @(posedge clock);
        if (cur_fire) rq.delete(0);
        if (e_wr) begin
            ref_mem[cur_wa] = cur_wd;
            last_a = cur_wa;
            last_d = cur_wd;
        end
        if (e_rd) begin
            rq.push_back('{data: ref_mem[cur_ra], gcyc: cyc});
            last_a = cur_ra;
        end
        if (e_wr || !cur_wv) streak_m = 0;
        else if (e_rd && streak_m < MAX) streak_m++;
        cyc++;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && rq.size() > 0; i++) begin
            drive(0, '0, '0, 0, '0, 1);
            commit();
        end
        total++;
        if (rq.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d required=0", rq.size());
        end
    endtask

    task automatic test_reset();
        bus.w_valid = 0; bus.w_addr = '0; bus.w_data = '0;
        bus.r_valid = 0; bus.r_addr = '0; bus.resp_ready = 0;
        reset_n = 1'b0;
        #3;
        total++;
        if ({bus.sram_ceb, bus.sram_web, bus.resp_valid, bus.w_ready, bus.r_ready} !== 5'b11000) begin
            bad++;
            $display("FAIL reset_ctrl got=%b required=11000",
                     {bus.sram_ceb, bus.sram_web, bus.resp_valid, bus.w_ready, bus.r_ready});
        end
        total++;
        if (bus.sram_a !== '0 || bus.sram_d !== '0 || bus.resp_data !== '0) begin
            bad++;
            $display("FAIL reset_bus a=%h d=%h rdata=%h required 0", bus.sram_a, bus.sram_d, bus.resp_data);
        end
        bus.w_valid = 1; bus.r_valid = 1;
        #1;
        total++;
        if ({bus.w_ready, bus.r_ready} !== 2'b00) begin
            bad++;
            $display("FAIL reset_ready got=%b required=00", {bus.w_ready, bus.r_ready});
        end
        @(negedge clock);
        bus.w_valid = 0; bus.r_valid = 0;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            drive(0, '0, '0, 0, '0, 1);
            total++;
            if ({bus.sram_ceb, bus.sram_web, bus.resp_valid} !== 3'b110 || bus.resp_data !== '0) begin
                bad++;
                $display("FAIL idle cyc=%0d ceb/web/rv=%b rdata=%h required 110 and 0",
                         i, {bus.sram_ceb, bus.sram_web, bus.resp_valid}, bus.resp_data);
            end
            commit();
        end
    endtask

    task automatic test_write_read();
        drive(1, 10'd3, 64'hA5A5, 0, '0, 1);
        total++;
        if ({bus.w_ready, bus.sram_ceb, bus.sram_web} !== 3'b100 || bus.sram_a !== 10'd3 || bus.sram_d !== 64'hA5A5) begin
            bad++;
            $display("FAIL wr_issue rdy/ceb/web=%b a=%0d d=%h required 100 3 a5a5",
                     {bus.w_ready, bus.sram_ceb, bus.sram_web}, bus.sram_a, bus.sram_d);
        end
        commit();
        drive(0, '0, '0, 1, 10'd3, 1);
        total++;
        if ({bus.r_ready, bus.sram_ceb, bus.sram_web} !== 3'b101 || bus.sram_a !== 10'd3) begin
            bad++;
            $display("FAIL rd_issue rdy/ceb/web=%b a=%0d required 101 3",
                     {bus.r_ready, bus.sram_ceb, bus.sram_web}, bus.sram_a);
        end
        commit();
        drive(0, '0, '0, 0, '0, 1);
        total++;
        if (bus.resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL rd_early resp_valid=%b required=0", bus.resp_valid);
        end
        commit();
        drive(0, '0, '0, 0, '0, 1);
        total++;
        if (bus.resp_valid !== 1'b1 || bus.resp_data !== 64'hA5A5) begin
            bad++;
            $display("FAIL rd_data valid=%b data=%h required 1 a5a5", bus.resp_valid, bus.resp_data);
        end
        commit();
        // Give addresses 0..7 known contents for the later tests.
        for (int a = 0; a < 8; a++) begin
            drive(1, AW'(a), {$urandom, $urandom}, 0, '0, 1);
            total++;
            if (bus.w_ready !== 1'b1) begin
                bad++;
                $display("FAIL prefill addr=%0d w_ready=%b required=1", a, bus.w_ready);
            end
            commit();
        end
    endtask

    task automatic test_streak();
        drain();
        for (int i = 0; i < 15; i++) begin
            drive(1, AW'($urandom_range(7)), {$urandom, $urandom}, 1, AW'($urandom_range(7)), 1);
            total++;
            if ({bus.w_ready, bus.r_ready} !== ((i % 5 == 4) ? 2'b10 : 2'b01)) begin
                bad++;
                $display("FAIL streak i=%0d w/r=%b required=%b", i, {bus.w_ready, bus.r_ready},
                         (i % 5 == 4) ? 2'b10 : 2'b01);
            end
            if (e_rv) begin
                total++;
                if (bus.resp_data !== e_rdata) begin
                    bad++;
                    $display("FAIL streak_data i=%0d got=%h required=%h", i, bus.resp_data, e_rdata);
                end
            end
            commit();
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] expd [4];
        int acc = 0;
        int got = 0;
        drive(0, '0, '0, 0, '0, 1);
        commit();
        drain();
        for (int k = 0; k < 4; k++) expd[k] = ref_mem[k];
        for (int i = 0; i < 4; i++) begin
            drive(0, '0, '0, 1, AW'(acc), 0);
            if (i >= 2) begin
                total++;
                if (bus.r_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL bp_stall i=%0d r_ready=%b required=0", i, bus.r_ready);
                end
            end
            if (bus.r_ready) acc++;
            commit();
        end
        total++;
        if (acc != 2) begin
            bad++;
            $display("FAIL bp_accepted got=%0d required=2", acc);
        end
        for (int i = 0; i < 20 && got < 4; i++) begin
            drive(0, '0, '0, acc < 4, AW'(acc), 1);
            total++;
            if (bus.resp_valid !== e_rv || bus.r_ready !== e_rd) begin
                bad++;
                $display("FAIL bp_hs i=%0d rv/rr=%b required=%b", i, {bus.resp_valid, bus.r_ready}, {e_rv, e_rd});
            end
            if (bus.r_ready) acc++;
            if (bus.resp_valid) begin
                total++;
                if (bus.resp_data !== expd[got]) begin
                    bad++;
                    $display("FAIL bp_order idx=%0d got=%h required=%h", got, bus.resp_data, expd[got]);
                end
                got++;
            end
            commit();
        end
        total++;
        if (got != 4) begin
            bad++;
            $display("FAIL bp_delivered got=%0d required=4", got);
        end
    endtask

    task automatic test_stream();
        drain();
        for (int i = 0; i < 20; i++) begin
            drive(0, '0, '0, 1, AW'($urandom_range(7)), 1);
            total++;
            if (bus.r_ready !== 1'b1) begin
                bad++;
                $display("FAIL stream_rdy i=%0d r_ready=%b required=1", i, bus.r_ready);
            end
            if (i >= 2) begin
                total++;
                if (bus.resp_valid !== 1'b1 || bus.resp_data !== e_rdata) begin
                    bad++;
                    $display("FAIL stream_resp i=%0d valid=%b data=%h required 1 %h",
                             i, bus.resp_valid, bus.resp_data, e_rdata);
                end
            end
            commit();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(1), AW'($urandom_range(7)), {$urandom, $urandom},
                  ($urandom_range(9) < 6), AW'($urandom_range(7)), ($urandom_range(9) < 7));
            total++;
            if ({bus.w_ready, bus.r_ready, bus.sram_ceb, bus.sram_web, bus.resp_valid} !==
                {e_wr, e_rd, e_ceb, e_web, e_rv}) begin
                bad++;
                $display("FAIL rand_ctrl i=%0d got=%b required=%b", i,
                         {bus.w_ready, bus.r_ready, bus.sram_ceb, bus.sram_web, bus.resp_valid},
                         {e_wr, e_rd, e_ceb, e_web, e_rv});
            end
            total++;
            if (bus.sram_a !== e_a || bus.sram_d !== e_d) begin
                bad++;
                $display("FAIL rand_pins i=%0d a=%0d d=%h required %0d %h", i, bus.sram_a, bus.sram_d, e_a, e_d);
            end
            if (e_rv) begin
                total++;
                if (bus.resp_data !== e_rdata) begin
                    bad++;
                    $display("FAIL rand_data i=%0d got=%h required=%h", i, bus.resp_data, e_rdata);
                end
            end
            commit();
        end
    endtask

    task automatic test_reset_mid();
        drain();
        drive(0, '0, '0, 1, 10'd1, 0);
        commit();
        drive(0, '0, '0, 1, 10'd2, 0);
        commit();
        @(negedge clock);
        bus.r_valid = 1; bus.resp_ready = 0;
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if ({bus.sram_ceb, bus.sram_web, bus.resp_valid, bus.w_ready, bus.r_ready} !== 5'b11000 ||
            bus.sram_a !== '0 || bus.sram_d !== '0 || bus.resp_data !== '0) begin
            bad++;
            $display("FAIL mid_reset ctrl=%b a=%0d d=%h rdata=%h required 11000 0 0 0",
                     {bus.sram_ceb, bus.sram_web, bus.resp_valid, bus.w_ready, bus.r_ready},
                     bus.sram_a, bus.sram_d, bus.resp_data);
        end
        @(negedge clock);
        bus.r_valid = 0;
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            drive(0, '0, '0, 0, '0, 1);
            total++;
            if (bus.resp_valid !== 1'b0) begin
                bad++;
                $display("FAIL post_reset i=%0d resp_valid=%b required=0", i, bus.resp_valid);
            end
            commit();
        end
        drive(0, '0, '0, 1, 10'd5, 1);
        commit();
        drive(0, '0, '0, 0, '0, 1);
        commit();
        drive(0, '0, '0, 0, '0, 1);
        total++;
        if (bus.resp_valid !== 1'b1 || bus.resp_data !== ref_mem[5]) begin
            bad++;
            $display("FAIL post_reset_rd valid=%b data=%h required 1 %h", bus.resp_valid, bus.resp_data, ref_mem[5]);
        end
        commit();
    endtask

    initial begin
        test_reset();
        test_idle();
        test_write_read();
        test_streak();
        test_backpressure();
        test_stream();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
